// File: rtl/mem_bus_if.sv
// MAR/MDR memory-interface unit: holds the address/data registers and runs
// read/write transactions to synchronous SRAM with a fixed number of wait states.
module mem_bus_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] databus,
  input  logic              load_mar,
  input  logic              load_mdr,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] data_from_mem,
  output logic [ADDR_W-1:0] mar,
  output logic [DATA_W-1:0] mdr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] data_to_mem,
  output logic              mem_ce_n,
  output logic              mem_we_n,
  output logic              busy,
  output logic              done,
  output logic              req_drop
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  localparam logic [3:0] RdInit = 4'(RD_WAIT - 1);
  localparam logic [3:0] WrInit = 4'(WR_WAIT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              req_drop_q, req_drop_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mar_d      = mar_q;
    mdr_d      = mdr_q;
    // Any request seen outside IDLE is discarded and flagged next cycle.
    req_drop_d = (state_q != StIdle) && mem_req;
    case (state_q)
      StIdle: begin
        if (load_mar) mar_d = databus[ADDR_W-1:0];
        if (load_mdr) mdr_d = databus;
        if (mem_req) begin
          if (mem_we) begin
            state_d = StWr;
            cnt_d   = WrInit;
          end else begin
            state_d = StRd;
            cnt_d   = RdInit;
          end
        end
      end
      StRd: begin
        if (cnt_q == 4'd0) begin
          mdr_d   = data_from_mem;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWr: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      mar_q      <= '0;
      mdr_q      <= '0;
      req_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mar_q      <= mar_d;
      mdr_q      <= mdr_d;
      req_drop_q <= req_drop_d;
    end
  end

  // Strobes decode the state register only, so reset deasserts them at once.
  assign busy        = (state_q == StRd) || (state_q == StWr);
  assign mem_ce_n    = !busy;
  assign mem_we_n    = (state_q != StWr);
  assign done        = (state_q == StDone);
  assign req_drop    = req_drop_q;
  assign mar         = mar_q;
  assign mdr         = mdr_q;
  assign mem_addr    = mar_q;
  assign data_to_mem = mdr_q;

endmodule

// File: doc/mem_bus_if.md
Name: mem_bus_if

Overview:
Parametrised MAR/MDR memory-interface unit for the SLC-3 datapath. Holds MAR and MDR, loads both from the CPU databus, and runs read/write transactions to synchronous SRAM with configurable wait states. A control FSM sequences chip-enable and write-enable, captures read data into MDR, and reports busy/done to the ISDU.

Parameters:
DATA_W, 16, width of databus, MDR and memory data
ADDR_W, 16, width of MAR and memory address (ADDR_W <= DATA_W)
RD_WAIT, 2, cycles mem_ce_n is held low for a read (legal range 1..15)
WR_WAIT, 2, cycles mem_we_n is held low for a write (legal range 1..15)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
databus  in  DATA_W  CPU bus value
load_mar  in  1  MAR <= databus[ADDR_W-1:0]
load_mdr  in  1  MDR <= databus
mem_req  in  1  start a transaction (sampled in IDLE only)
mem_we  in  1  transaction type qualifier: 1 = write, 0 = read
data_from_mem  in  DATA_W  SRAM read data
mar  out  ADDR_W  MAR register
mdr  out  DATA_W  MDR register (gateMDR source)
mem_addr  out  ADDR_W  equals mar
data_to_mem  out  DATA_W  equals mdr
mem_ce_n  out  1  SRAM chip enable, active-low
mem_we_n  out  1  SRAM write enable, active-low
busy  out  1  high in RD or WR
done  out  1  one-cycle completion pulse
req_drop  out  1  one-cycle pulse when mem_req is ignored

Behaviour:
- Reset is asynchronous and active-high. Clk is the only clock.
- Reset values: mar=0, mdr=0, state=IDLE, mem_ce_n=1, mem_we_n=1, busy=0, done=0, req_drop=0.
- States are IDLE, RD, WR and DONE. All outputs are registered or are decodes of the state register only.
- IDLE:
  - load_mar and load_mdr take effect at the clock edge.
  - mem_req=1 and mem_we=0: go to RD, cnt <= RD_WAIT-1.
  - mem_req=1 and mem_we=1: go to WR, cnt <= WR_WAIT-1.
- Same-edge load and request: the load applies first. The transaction uses the newly loaded MAR/MDR.
- RD:
  - Outputs: mem_ce_n=0, mem_we_n=1, busy=1.
  - Each edge: if cnt==0 then MDR <= data_from_mem and go to DONE; otherwise cnt decrements.
  - mem_ce_n is low for exactly RD_WAIT cycles.
- WR:
  - Outputs: mem_ce_n=0, mem_we_n=0, busy=1.
  - mem_addr and data_to_mem are stable for the whole state.
  - After WR_WAIT cycles go to DONE. MDR is unchanged.
- DONE:
  - Outputs: done=1, busy=0, mem_ce_n=1, mem_we_n=1.
  - Always returns to IDLE on the next edge.
- Latency: a request accepted at edge k gives done high during cycle k+N+1, where N = RD_WAIT or WR_WAIT.
- In RD, WR and DONE:
  - load_mar and load_mdr are ignored. MAR and MDR are frozen, except the read capture into MDR.
  - mem_req=1 is ignored, with no queuing. req_drop=1 for the following cycle, once per ignored cycle.
- cnt width is 4 bits. No wrap-around is possible within the legal parameter range.
- Reset mid-transaction:
  - Immediate return to IDLE. mem_ce_n and mem_we_n deassert asynchronously.
  - No MDR capture and no done pulse.
  - mar and mdr are cleared.
- MAR loads truncate: only databus[ADDR_W-1:0] is used and upper bits are ignored.

Test Plan:
- Reset: assert Reset mid-cycle -> mar=0, mdr=0, mem_ce_n=1, mem_we_n=1, busy=0 with no clock edge required.
- Read, RD_WAIT=2:
  - Stimulus: load_mar with databus=0x3000, then mem_req=1, mem_we=0; data_from_mem=0xBEEF.
  - Response: mem_ce_n low exactly 2 cycles with mem_addr=0x3000, then mdr=0xBEEF and a single-cycle done, 3 cycles after accept.
- Write, WR_WAIT=3:
  - Stimulus: load_mdr with databus=0x1234 on the same edge as mem_req=1, mem_we=1, mar=0x00FF.
  - Response: mem_we_n low 3 cycles with data_to_mem=0x1234 and mem_addr=0x00FF, then done; mdr stays 0x1234.
- Busy rejection:
  - Stimulus: during RD, drive mem_req=1 for 2 cycles and load_mar with databus=0x5555.
  - Response: two req_drop pulses; mar unchanged; after done, FSM returns to IDLE with no second transaction.
- Reset abort: assert Reset during WR cycle 2 -> mem_we_n=1 immediately, no done, state IDLE; a read after release completes normally.
- Parametrised instance, DATA_W=8, ADDR_W=6, RD_WAIT=1:
  - Stimulus: load_mar with databus=0xFF, then a read with data_from_mem=0xA5.
  - Response: mar=0x3F; mem_ce_n low 1 cycle; mdr=0xA5; done 2 cycles after accept.
